ins_line_fetch: RTL
===================

# ins_line_fetch

Upstream feeder for the SPU instruction fetch stage. On a line request it reads one 64-byte instruction line (16 instructions) from local store as four 128-bit quadwords. It assembles them into the 16-entry instruction line buffer and presents the full line atomically, with a valid flag. Sits between the local store read port and the IF stage, and consumes IF's `read_enable` and `pc`.

## Interface
Parameters:
- `LS_LAT`, default 6: fixed local-store read latency in cycles (request cycle to data cycle).
- `BASE_QW`, default 0: local-store quadword address of program instruction 0.

Ports:
- `clk`, input, 1: the single clock.
- `reset`, input, 1: synchronous, active-high.
- `read_enable`, input, 1: line request from IF, sampled on the rising edge.
- `pc`, input, 8: instruction index from IF; requested line is `pc[7:4]`.
- `ls_rd_en`, output, 1: local-store read strobe.
- `ls_addr`, output, 14: local-store quadword address.
- `ls_rd_data`, input, [0:127]: read data, valid exactly `LS_LAT` cycles after the matching `ls_rd_en` cycle.
- `ins_cache`, output, [0:31] x [0:15]: current instruction line; word 0 is `ls_rd_data[0:31]` of quadword 0.
- `line_valid`, output, 1: `ins_cache` holds a complete line.
- `line_tag`, output, 4: line number held in `ins_cache`.
- `busy`, output, 1: a fill is in progress.

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE, `read_enable`=1:
  - If `line_valid`=1 and `pc[7:4]`==`line_tag`, it is a hit: no action, outputs unchanged.
  - Otherwise it is a miss: latch the request tag, clear `line_valid`, set `busy`, go to ISSUE.
- ISSUE: four consecutive cycles with `ls_rd_en`=1.
  - `ls_addr` = `BASE_QW + tag*4 + q`, for q = 0..3. Arithmetic is modulo 2^14 and wraps silently.
  - Then go to DRAIN.
- Return tracking: a delay line of depth `LS_LAT` carries {valid, q} for each issued read. Each return is written into a 4x128-bit staging buffer at slot q.
- DRAIN: when the q=3 return is captured:
  - Copy the staging buffer into `ins_cache` (word 4q+k comes from `ls_rd_data[32k:32k+31]` of quadword q).
  - Set `line_tag` to the request tag and `line_valid` to 1.
  - Clear `busy` and go to IDLE.
- `ins_cache` changes only on a full-line commit. During a fill it continues to show the old line, but `line_valid` is 0.
- Request while `busy`: record it in a one-entry pending register; a newer request overwrites an older one.
  - On commit, if the pending tag differs from the committed tag, start a new miss in the next cycle instead of going to IDLE.
  - If the pending tag equals the committed tag, drop it.
- `read_enable` in the same cycle as a commit counts as pending.
- Reset:
  - Clears the FSM, delay line, pending register and staging buffer.
  - Sets `ins_cache` to all zero, `line_tag`=0, `line_valid`=0, `busy`=0, `ls_rd_en`=0, `ls_addr`=0.
  - Any reads still in flight at reset are discarded when their data returns.
- After reset, IF drives `read_enable`=1. The first request with `pc`=0 is therefore a miss and fetches line 0.

## Timing
- Request sampled at edge T (miss, from IDLE):
  - `ls_rd_en`=1 in cycles T+1..T+4.
  - Returns arrive in cycles T+1+LS_LAT..T+4+LS_LAT.
  - `line_valid`=1 and the new `ins_cache` are visible from cycle T+5+LS_LAT. With the default `LS_LAT`, that is 11 cycles after the request edge.
- Back-to-back miss via pending: the next `ls_rd_en` is asserted in the cycle immediately after the commit edge.
- Hit: zero latency; `line_valid` never drops.
- All outputs are registered.

## Structure
- Shared package `spu_fetch_pkg`:
  - `instr_t` (logic [0:31]) and `qword_t` (logic [0:127]).
  - `LINE_WORDS`=16, `QW_PER_LINE`=4.
  - FSM state enum `lf_state_t`.
- One sub-module, `ls_lat_pipe`: a parameterized fixed-latency shift register carrying {valid, q[1:0]}, with synchronous clear on reset.

## Test plan
- Reset, then `read_enable`=1 with `pc`=0 and an LS model holding word i = 32'h1000_0000+i:
  - `ls_addr` sequence 0,1,2,3.
  - `line_valid` rises in cycle 11, `ins_cache[5]`=32'h1000_0005, `line_tag`=0.
- `pc`=16, then `pc`=32 one cycle later during the fill:
  - Line 1 commits (`ins_cache[0]`=32'h1000_0010).
  - The line 2 fill starts the next cycle with `ls_addr` 8..11.
- Hit: `line_tag`=2, `line_valid`=1, `read_enable` with `pc`=34 → no `ls_rd_en`, outputs unchanged.
- `BASE_QW`=14'h3FFE with line 0:
  - `ls_addr` = 3FFE, 3FFF, 0000, 0001 (wrap).
- Reset asserted in cycle 3 of ISSUE:
  - All outputs return to reset values.
  - Data still returning afterwards does not change `ins_cache` or assert `line_valid`.
- `LS_LAT`=1 build: line commit is visible 6 cycles after the request edge, with correct word ordering.

Source files
------------

// File: rtl/spu_fetch_pkg.sv
// Shared types and constants for the SPU instruction fetch path.
package spu_fetch_pkg;

    typedef logic [0:31]  instr_t;
    typedef logic [0:127] qword_t;

    localparam int LINE_WORDS  = 16;
    localparam int QW_PER_LINE = 4;

    typedef enum logic [1:0] {
        LF_IDLE  = 2'd0,
        LF_ISSUE = 2'd1,
        LF_DRAIN = 2'd2
    } lf_state_t;

    // Local-store quadword address of quadword q of line tag; wraps modulo 2^14.
    function automatic logic [13:0] lf_qw_addr(input logic [13:0] base,
                                               input logic [3:0]  tag,
                                               input logic [1:0]  q);
        return base + {8'd0, tag, 2'b00} + {12'd0, q};
    endfunction

endpackage

// File: rtl/ins_line_fetch_ls_lat_pipe.sv
// Fixed-latency delay line carrying {valid, q} alongside local-store reads,
// so each returning quadword can be steered into its staging slot.
module ls_lat_pipe #(
    parameter int DEPTH = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [1:0] in_q,
    output logic       out_valid,
    output logic [1:0] out_q
);

    logic [2:0] stage_r [0:DEPTH-1];

    // Shift the read tags one stage per cycle; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= 3'd0;
            end
        end else begin
            stage_r[0] <= {in_valid, in_q};
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign out_valid = stage_r[DEPTH-1][2];
    assign out_q     = stage_r[DEPTH-1][1:0];

endmodule

// File: rtl/ins_line_fetch.sv
// Instruction line fetcher: reads one 64-byte line as four quadwords from
// local store and presents it to the IF stage as an atomic 16-word line.
module ins_line_fetch
    import spu_fetch_pkg::*;
#(
    parameter int          LS_LAT  = 6,
    parameter logic [13:0] BASE_QW = 14'd0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         read_enable,
    input  logic [7:0]   pc,
    output logic         ls_rd_en,
    output logic [13:0]  ls_addr,
    input  logic [0:127] ls_rd_data,
    output logic [0:31]  ins_cache [0:15],
    output logic         line_valid,
    output logic [3:0]   line_tag,
    output logic         busy
);

    lf_state_t   state_r, state_next_s;
    logic [3:0]  req_tag_r, req_tag_next_s;
    logic [1:0]  issue_q_r, issue_q_next_s;
    logic        ls_rd_en_r, ls_rd_en_next_s;
    logic [13:0] ls_addr_r, ls_addr_next_s;
    logic        line_valid_r, line_valid_next_s;
    logic [3:0]  line_tag_r, line_tag_next_s;
    logic        busy_r, busy_next_s;
    logic        pend_valid_r, pend_valid_next_s;
    logic [3:0]  pend_tag_r, pend_tag_next_s;

    qword_t      stage_r [0:QW_PER_LINE-1];
    instr_t      cache_r [0:LINE_WORDS-1];
    instr_t      line_s  [0:LINE_WORDS-1];

    logic [3:0]  pc_tag_s;
    logic        pc_unused_s;
    logic        ret_valid_s;
    logic [1:0]  ret_q_s;
    logic        hit_s;
    logic        commit_s;
    logic        chain_valid_s;
    logic [3:0]  chain_tag_s;
    logic        start_fill_s;
    logic [3:0]  start_tag_s;

    assign pc_tag_s    = pc[7:4];
    assign pc_unused_s = ^pc[3:0];

    ls_lat_pipe #(.DEPTH(LS_LAT)) u_lat_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (ls_rd_en_r),
        .in_q      (issue_q_r),
        .out_valid (ret_valid_s),
        .out_q     (ret_q_s)
    );

    // A request arriving in the commit cycle takes precedence over the stored pending one.
    assign hit_s         = line_valid_r && (pc_tag_s == line_tag_r);
    assign commit_s      = (state_r == LF_DRAIN) && ret_valid_s && (ret_q_s == 2'd3);
    assign chain_valid_s = read_enable || pend_valid_r;
    assign chain_tag_s   = read_enable ? pc_tag_s : pend_tag_r;
    assign line_tag_next_s = commit_s ? req_tag_r : line_tag_r;

    // Decide whether a new fill starts this cycle: a miss from idle or a chained miss on commit.
    always_comb begin
        start_fill_s = 1'b0;
        start_tag_s  = pc_tag_s;
        case (state_r)
            LF_IDLE: begin
                start_fill_s = read_enable && !hit_s;
                start_tag_s  = pc_tag_s;
            end
            LF_DRAIN: begin
                start_fill_s = commit_s && chain_valid_s && (chain_tag_s != req_tag_r);
                start_tag_s  = chain_tag_s;
            end
            default: begin
                start_fill_s = 1'b0;
                start_tag_s  = pc_tag_s;
            end
        endcase
    end

    // Next-state and next-output logic for the fetch FSM.
    always_comb begin
        state_next_s      = state_r;
        req_tag_next_s    = req_tag_r;
        issue_q_next_s    = issue_q_r;
        ls_rd_en_next_s   = 1'b0;
        ls_addr_next_s    = ls_addr_r;
        line_valid_next_s = line_valid_r;
        busy_next_s       = busy_r;
        pend_valid_next_s = pend_valid_r;
        pend_tag_next_s   = pend_tag_r;
        if (start_fill_s) begin
            state_next_s      = LF_ISSUE;
            req_tag_next_s    = start_tag_s;
            issue_q_next_s    = 2'd0;
            ls_rd_en_next_s   = 1'b1;
            ls_addr_next_s    = lf_qw_addr(BASE_QW, start_tag_s, 2'd0);
            line_valid_next_s = 1'b0;
            busy_next_s       = 1'b1;
            pend_valid_next_s = 1'b0;
        end else begin
            case (state_r)
                LF_IDLE: begin
                    state_next_s = LF_IDLE;
                end
                LF_ISSUE: begin
                    if (issue_q_r == 2'd3) begin
                        state_next_s = LF_DRAIN;
                    end else begin
                        issue_q_next_s  = issue_q_r + 2'd1;
                        ls_rd_en_next_s = 1'b1;
                        ls_addr_next_s  = lf_qw_addr(BASE_QW, req_tag_r, issue_q_r + 2'd1);
                    end
                    if (read_enable) begin
                        pend_valid_next_s = 1'b1;
                        pend_tag_next_s   = pc_tag_s;
                    end else begin
                        pend_valid_next_s = pend_valid_r;
                    end
                end
                LF_DRAIN: begin
                    if (commit_s) begin
                        // Pending request (if any) matches the committed line: drop it.
                        state_next_s      = LF_IDLE;
                        line_valid_next_s = 1'b1;
                        busy_next_s       = 1'b0;
                        pend_valid_next_s = 1'b0;
                    end else if (read_enable) begin
                        pend_valid_next_s = 1'b1;
                        pend_tag_next_s   = pc_tag_s;
                    end else begin
                        pend_valid_next_s = pend_valid_r;
                    end
                end
                default: begin
                    state_next_s = LF_IDLE;
                    busy_next_s  = 1'b0;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= LF_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Registered control outputs, request tag, issue counter and pending request.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_tag_r    <= 4'd0;
            issue_q_r    <= 2'd0;
            ls_rd_en_r   <= 1'b0;
            ls_addr_r    <= 14'd0;
            line_valid_r <= 1'b0;
            line_tag_r   <= 4'd0;
            busy_r       <= 1'b0;
            pend_valid_r <= 1'b0;
            pend_tag_r   <= 4'd0;
        end else begin
            req_tag_r    <= req_tag_next_s;
            issue_q_r    <= issue_q_next_s;
            ls_rd_en_r   <= ls_rd_en_next_s;
            ls_addr_r    <= ls_addr_next_s;
            line_valid_r <= line_valid_next_s;
            line_tag_r   <= line_tag_next_s;
            busy_r       <= busy_next_s;
            pend_valid_r <= pend_valid_next_s;
            pend_tag_r   <= pend_tag_next_s;
        end
    end

    // Capture each returning quadword into its staging slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int q = 0; q < QW_PER_LINE; q++) begin
                stage_r[q] <= 128'd0;
            end
        end else if (ret_valid_s) begin
            stage_r[ret_q_s] <= ls_rd_data;
        end else begin
            stage_r[ret_q_s] <= stage_r[ret_q_s];
        end
    end

    // Assemble the full line; the last quadword is taken straight from the read bus.
    always_comb begin
        for (int w = 0; w < LINE_WORDS; w++) begin
            line_s[w] = 32'd0;
        end
        for (int q = 0; q < QW_PER_LINE; q++) begin
            for (int k = 0; k < 4; k++) begin
                if (q == (QW_PER_LINE - 1)) begin
                    line_s[4*q+k] = ls_rd_data[32*k +: 32];
                end else begin
                    line_s[4*q+k] = stage_r[q][32*k +: 32];
                end
            end
        end
    end

    // Instruction line register: only ever updated by a complete-line commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < LINE_WORDS; w++) begin
                cache_r[w] <= 32'd0;
            end
        end else if (commit_s) begin
            for (int w = 0; w < LINE_WORDS; w++) begin
                cache_r[w] <= line_s[w];
            end
        end else begin
            for (int w = 0; w < LINE_WORDS; w++) begin
                cache_r[w] <= cache_r[w];
            end
        end
    end

    assign ins_cache  = cache_r;
    assign ls_rd_en   = ls_rd_en_r;
    assign ls_addr    = ls_addr_r;
    assign line_valid = line_valid_r;
    assign line_tag   = line_tag_r;
    assign busy       = busy_r;

endmodule
